// File: rtl/modport_pkt_proc_if.sv
// Write/read handshake, thresholds and status bundle of the packet FIFO.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface modport_pkt_proc_if;
    logic        empty_de_assert;
    logic        enq_req, in_sop, in_eop;
    logic [31:0] wr_data_i;
    logic        pck_len_valid;
    logic [11:0] pck_len_i;
    logic        deq_req;
    logic [31:0] rd_data_o;
    logic        out_sop, out_eop;
    logic [4:0]  pck_proc_almost_full_value, pck_proc_almost_empty_value;
    logic        pck_proc_full, pck_proc_empty, pck_proc_almost_full, pck_proc_almost_empty;
    logic        pck_proc_overflow, pck_proc_underflow, packet_drop;
    logic [13:0] pck_proc_wr_lvl;

    modport slave (
        input  empty_de_assert, enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i,
               deq_req, pck_proc_almost_full_value, pck_proc_almost_empty_value,
        output rd_data_o, out_sop, out_eop, pck_proc_full, pck_proc_empty, pck_proc_almost_full,
               pck_proc_almost_empty, pck_proc_overflow, pck_proc_underflow, packet_drop,
               pck_proc_wr_lvl
    );

    modport master (
        output empty_de_assert, enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i,
               deq_req, pck_proc_almost_full_value, pck_proc_almost_empty_value,
        input  rd_data_o, out_sop, out_eop, pck_proc_full, pck_proc_empty, pck_proc_almost_full,
               pck_proc_almost_empty, pck_proc_overflow, pck_proc_underflow, packet_drop,
               pck_proc_wr_lvl
    );
endinterface

// File: rtl/modport_pkt_proc.sv
// Packet FIFO: words are written speculatively and become readable on commit;
// malformed or oversized packets are rewound and reported with packet_drop.
module modport_pkt_proc #(
    parameter int DEPTH = 4096
) (
    input  logic              pck_proc_int_mem_fsm_clk,
    input  logic              pck_proc_int_mem_fsm_rstn,
    input  logic              pck_proc_int_mem_fsm_sw_rstn,
    modport_pkt_proc_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    logic        clk, rstn, sw_rstn;
    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, commit_ptr_q, rd_ptr_q;
    logic [11:0] len_q, len_d, cnt_q, cnt_d;
    logic [31:0] rd_data_q;
    logic        out_sop_q, out_eop_q, drop_q, ovf_q, udf_q;
    logic [33:0] mem [DEPTH];

    logic [AW:0] lvl, free;
    logic        full, empty, rd_ok, wr_en, commit, drop, last_word, len_ok;

    assign clk     = pck_proc_int_mem_fsm_clk;
    assign rstn    = pck_proc_int_mem_fsm_rstn;
    assign sw_rstn = pck_proc_int_mem_fsm_sw_rstn;

    assign lvl    = wr_ptr_q - rd_ptr_q;
    assign free   = DEPTH_W - lvl;
    assign full   = (lvl == DEPTH_W);
    assign empty  = bus.empty_de_assert ? (rd_ptr_q == commit_ptr_q) : (lvl == '0);
    assign rd_ok  = bus.deq_req && !empty;
    assign len_ok = bus.pck_len_valid && (bus.pck_len_i != '0) && ((AW+1)'(bus.pck_len_i) <= free);
    // The word being offered is the packet's last one exactly when its index hits the length.
    assign last_word = (state_q == IDLE) ? (bus.pck_len_i == 12'd1) : (cnt_q + 12'd1 == len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        if (bus.enq_req) begin
            unique case (state_q)
                IDLE: if (bus.in_sop) begin
                    if (!len_ok || (bus.in_eop != last_word)) begin
                        drop    = 1'b1;
                        state_d = bus.in_eop ? IDLE : DROP;
                    end else begin
                        wr_en   = 1'b1;
                        commit  = bus.in_eop;
                        state_d = bus.in_eop ? IDLE : WRITE;
                        len_d   = bus.pck_len_i;
                        cnt_d   = 12'd1;
                    end
                end
                WRITE: if (bus.in_sop || full || (bus.in_eop != last_word)) begin
                    drop    = 1'b1;
                    state_d = bus.in_eop ? IDLE : DROP;
                end else begin
                    wr_en   = 1'b1;
                    commit  = bus.in_eop;
                    state_d = bus.in_eop ? IDLE : WRITE;
                    cnt_d   = cnt_q + 12'd1;
                end
                DROP: if (bus.in_eop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && sw_rstn) mem[wr_ptr_q[AW-1:0]] <= {bus.in_eop, bus.in_sop, bus.wr_data_i};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            drop_q       <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else if (!sw_rstn) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            drop_q       <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop;
            ovf_q   <= bus.enq_req && full;
            udf_q   <= bus.deq_req && empty;
            // In IDLE wr_ptr already equals commit_ptr, so rewinding there is harmless.
            if (wr_en)     wr_ptr_q <= wr_ptr_q + 1'b1;
            else if (drop) wr_ptr_q <= commit_ptr_q;
            if (commit)    commit_ptr_q <= wr_ptr_q + 1'b1;
            out_sop_q <= rd_ok && mem[rd_ptr_q[AW-1:0]][32];
            out_eop_q <= rd_ok && mem[rd_ptr_q[AW-1:0]][33];
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]][31:0];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign bus.rd_data_o             = rd_data_q;
    assign bus.out_sop               = out_sop_q;
    assign bus.out_eop               = out_eop_q;
    assign bus.packet_drop           = drop_q;
    assign bus.pck_proc_overflow     = ovf_q;
    assign bus.pck_proc_underflow    = udf_q;
    assign bus.pck_proc_wr_lvl       = 14'(lvl);
    assign bus.pck_proc_full         = full;
    assign bus.pck_proc_empty        = empty;
    assign bus.pck_proc_almost_full  = (lvl >= DEPTH_W - (AW+1)'(bus.pck_proc_almost_full_value));
    assign bus.pck_proc_almost_empty = (lvl <= (AW+1)'(bus.pck_proc_almost_empty_value));
endmodule

// File: tb/tb_modport_pkt_proc.sv
// Randomized bench for modport_pkt_proc against a queue-based packet model.
module tb_modport_pkt_proc;
    logic clk = 1'b0, rstn = 1'b0, sw_rstn = 1'b1;
    modport_pkt_proc_if bus ();

    modport_pkt_proc dut (
        .pck_proc_int_mem_fsm_clk    (clk),
        .pck_proc_int_mem_fsm_rstn   (rstn),
        .pck_proc_int_mem_fsm_sw_rstn(sw_rstn),
        .bus                         (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Model: every stored word in order; the first ncom of them are committed.
    logic [33:0] q [$];
    int          ncom, mstate, mlen, mcnt;   // mstate: 0 idle, 1 in packet, 2 discarding
    logic [31:0] e_data;
    logic        e_sop, e_eop, e_drop, e_ovf, e_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ncom = 0; mstate = 0; mlen = 0; mcnt = 0;
        e_data = '0; e_sop = 0; e_eop = 0; e_drop = 0; e_ovf = 0; e_udf = 0;
    endtask

    task automatic model_step();
        int          lvl   = q.size();
        bit          full  = (lvl == 4096);
        bit          empty = bus.empty_de_assert ? (ncom == 0) : (lvl == 0);
        int          len   = int'(bus.pck_len_i);
        logic [33:0] w;
        e_udf = bus.deq_req && empty;
        e_sop = 0; e_eop = 0;
        if (bus.deq_req && !empty) begin
            w = q.pop_front();
            if (ncom > 0) ncom--;
            e_data = w[31:0]; e_sop = w[32]; e_eop = w[33];
        end
        e_ovf  = bus.enq_req && full;
        e_drop = 0;
        if (bus.enq_req) begin
            if (mstate == 0 && bus.in_sop) begin
                if (!bus.pck_len_valid || len == 0 || len > 4096 - lvl || bus.in_eop != (len == 1)) begin
                    e_drop = 1; mstate = bus.in_eop ? 0 : 2;
                end else begin
                    q.push_back({bus.in_eop, 1'b1, bus.wr_data_i});
                    mlen = len; mcnt = 1;
                    if (bus.in_eop) ncom = q.size(); else mstate = 1;
                end
            end else if (mstate == 1) begin
                if (bus.in_sop || full || bus.in_eop != (mcnt + 1 == mlen)) begin
                    e_drop = 1;
                    while (q.size() > ncom) void'(q.pop_back());
                    mstate = bus.in_eop ? 0 : 2;
                end else begin
                    q.push_back({bus.in_eop, 1'b0, bus.wr_data_i});
                    mcnt++;
                    if (bus.in_eop) begin ncom = q.size(); mstate = 0; end
                end
            end else if (mstate == 2 && bus.in_eop) begin
                mstate = 0;
            end
        end
    endtask

    task automatic check_all();
        int lvl = q.size();
        chk("rd_data",   bus.rd_data_o, e_data);
        chk("out_sop",   32'(bus.out_sop), 32'(e_sop));
        chk("out_eop",   32'(bus.out_eop), 32'(e_eop));
        chk("drop",      32'(bus.packet_drop), 32'(e_drop));
        chk("overflow",  32'(bus.pck_proc_overflow), 32'(e_ovf));
        chk("underflow", 32'(bus.pck_proc_underflow), 32'(e_udf));
        chk("wr_lvl",    32'(bus.pck_proc_wr_lvl), 32'(lvl));
        chk("empty",     32'(bus.pck_proc_empty),
            bus.empty_de_assert ? 32'(ncom == 0) : 32'(lvl == 0));
        chk("full",      32'(bus.pck_proc_full), 32'(lvl == 4096));
        chk("a_full",    32'(bus.pck_proc_almost_full),
            32'(lvl >= 4096 - int'(bus.pck_proc_almost_full_value)));
        chk("a_empty",   32'(bus.pck_proc_almost_empty),
            32'(lvl <= int'(bus.pck_proc_almost_empty_value)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!sw_rstn) model_reset(); else model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input int enq, input int sop, input int eop, input int len,
                         input int lv, input int deq);
        bus.enq_req       = (enq != 0);
        bus.in_sop        = (sop != 0);
        bus.in_eop        = (eop != 0);
        bus.pck_len_i     = 12'(len);
        bus.pck_len_valid = (lv != 0);
        bus.deq_req       = (deq != 0);
        bus.wr_data_i     = $urandom();
        tick();
    endtask

    task automatic pkt(input int n, input int len);
        for (int w = 0; w < n; w++) drive(1, w == 0, w == n - 1, len, 1, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int rem = 0;
        int plen;
        bus.empty_de_assert = 1'b1;
        bus.enq_req = 0; bus.in_sop = 0; bus.in_eop = 0; bus.wr_data_i = '0;
        bus.pck_len_valid = 0; bus.pck_len_i = '0; bus.deq_req = 0;
        bus.pck_proc_almost_full_value  = 5'd4;
        bus.pck_proc_almost_empty_value = 5'd2;
        model_reset();
        #12;
        check_all();
        rstn = 1'b1;

        // Basic 4-word packet, read back in order.
        pkt(4, 4);
        drain(4);
        drive(0, 0, 0, 0, 0, 0);

        // Partial packet stays invisible until committed.
        drive(1, 1, 0, 3, 1, 0);
        drive(1, 0, 0, 3, 1, 0);
        drive(1, 0, 1, 3, 1, 0);
        drain(3);
        bus.empty_de_assert = 1'b0;
        drive(1, 1, 0, 3, 1, 0);
        drive(1, 0, 0, 3, 1, 0);
        drive(1, 0, 1, 3, 1, 0);
        drain(3);
        bus.empty_de_assert = 1'b1;

        // Malformed packets.
        pkt(2, 2);
        drive(1, 1, 0, 3, 1, 0); drive(1, 0, 1, 3, 1, 0);                 // early eop
        drive(1, 1, 0, 2, 1, 0); drive(1, 0, 0, 2, 1, 0); drive(1, 0, 1, 2, 1, 0); // no eop at len
        drive(1, 1, 0, 0, 1, 0); drive(1, 0, 1, 0, 1, 0);                 // zero length
        drive(1, 1, 1, 1, 0, 0);                                          // length not valid
        drive(1, 1, 0, 4, 1, 0); drive(1, 1, 0, 4, 1, 0); drive(1, 0, 1, 4, 1, 0); // sop mid-packet
        drive(1, 0, 0, 5, 1, 0);                                          // stray word in IDLE
        drive(1, 1, 1, 1, 1, 1);                                          // enq + deq together
        drain(3);

        // Underflow, then fill to full through the almost-full threshold.
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        pkt(4091, 4091);
        for (int i = 0; i < 5; i++) pkt(1, 1);
        drive(1, 1, 1, 1, 1, 0);
        drive(1, 0, 0, 1, 1, 0);
        drive(1, 1, 1, 1, 1, 1);
        drain(4097);

        // Soft reset mid-packet wins over same-cycle activity.
        pkt(2, 2);
        drive(1, 1, 0, 5, 1, 0);
        drive(1, 0, 0, 5, 1, 0);
        sw_rstn = 1'b0;
        drive(1, 0, 0, 5, 1, 1);
        sw_rstn = 1'b1;
        pkt(3, 3);
        drain(4);

        // Random traffic with occasional protocol errors.
        for (int i = 0; i < 3000; i++) begin
            int enq = ($urandom_range(0, 99) < 60);
            int deq = ($urandom_range(0, 99) < 45);
            int sop = 0, eop = 0, len = 0, lv = 1;
            if (enq != 0) begin
                if (rem == 0) begin
                    plen = $urandom_range(1, 6);
                    rem = plen; sop = 1; len = plen;
                    if ($urandom_range(0, 19) == 0) lv = 0;
                    if ($urandom_range(0, 19) == 0) len = 0;
                end else if ($urandom_range(0, 29) == 0) begin
                    sop = 1; len = rem;
                end
                rem--;
                eop = (rem == 0);
                if ($urandom_range(0, 24) == 0) eop = !eop;
                if (eop != 0) rem = 0;
            end
            drive(enq, sop, eop, len, lv, deq);
        end
        drain(64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/modport_pkt_proc.md
MODPORT_PKT_PROC -- requirements
Module: modport_pkt_proc

Interface
REQ-001 SHALL have port pck_proc_int_mem_fsm_clk, input, 1, the single clock; all logic on its rising edge.
REQ-002 SHALL have port pck_proc_int_mem_fsm_rstn, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port pck_proc_int_mem_fsm_sw_rstn, input, 1, synchronous active-low soft reset.
REQ-004 SHALL have port empty_de_assert, input, 1, when 1 the read side sees only committed (complete) packets.
REQ-005 SHALL have ports enq_req/in_sop/in_eop, input, 1 each, plus wr_data_i, input, 32: write word strobe and packet delimiters.
REQ-006 SHALL have ports pck_len_valid, input, 1, and pck_len_i, input, 12: packet length in words, sampled with in_sop.
REQ-007 SHALL have port deq_req, input, 1, plus outputs rd_data_o 32, out_sop 1, out_eop 1: read word and delimiters.
REQ-008 SHALL have inputs pck_proc_almost_full_value and pck_proc_almost_empty_value, 5 bits each, thresholds.
REQ-009 SHALL have outputs pck_proc_full, pck_proc_empty, pck_proc_almost_full, pck_proc_almost_empty, pck_proc_overflow, pck_proc_underflow, packet_drop, 1 bit each, and pck_proc_wr_lvl, 14 bits.

Function
REQ-010 SHALL store words in a 4096-entry x 34-bit memory (data + sop + eop flags); parameter DEPTH=4096.
REQ-011 SHALL keep wr_ptr, commit_ptr, rd_ptr (12 bits + wrap bit); pck_proc_wr_lvl = wr_ptr - rd_ptr, range 0..4096.
REQ-012 SHALL run a write FSM with states IDLE, WRITE, DROP.
REQ-013 IDLE: enq_req&in_sop&pck_len_valid with 1<=pck_len_i<=free space writes word, latches length, goes WRITE (or commits immediately if in_eop and length 1).
REQ-014 IDLE: enq_req without in_sop ignored; in_sop with pck_len_valid=0, pck_len_i=0, or pck_len_i>free space -> packet_drop pulse, DROP.
REQ-015 WRITE: each enq_req writes one word; in_eop on word count == length -> commit_ptr<=wr_ptr+1, go IDLE.
REQ-016 WRITE: in_eop early, count reaching length without in_eop, or new in_sop -> wr_ptr rewound to commit_ptr, packet_drop pulse 1 cycle, go DROP (IDLE if eop present).
REQ-017 DROP: discard enq_req words until in_eop, then IDLE; no memory writes.
REQ-018 enq_req while pck_proc_full -> pck_proc_overflow 1-cycle pulse, word not written, packet dropped per REQ-016.
REQ-019 deq_req when not empty -> rd_data_o/out_sop/out_eop registered from memory at rd_ptr, valid the following cycle; rd_ptr increments.
REQ-020 deq_req when empty -> pck_proc_underflow 1-cycle pulse, pointers unchanged, out_sop/out_eop 0, rd_data_o holds.
REQ-021 out_sop/out_eop SHALL be 0 in cycles without a successful read.
REQ-022 pck_proc_empty = (rd_ptr==commit_ptr) when empty_de_assert=1, else (wr_lvl==0); combinational from registers.
REQ-023 pck_proc_full = (wr_lvl==4096); almost_full = wr_lvl >= 4096-almost_full_value; almost_empty = wr_lvl <= almost_empty_value.
REQ-024 Simultaneous enq_req and deq_req SHALL both proceed in one cycle; level unchanged.
REQ-025 Pointers wrap modulo 4096 with wrap bit distinguishing full from empty.

Reset
REQ-026 rstn low (async) or sw_rstn low at clock edge clears pointers, FSM to IDLE, rd_data_o=0, all pulses 0, wr_lvl=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-027 Reset mid-packet SHALL discard the partial packet; no drop pulse generated.
REQ-028 sw_rstn has priority over all enq/deq activity in the same cycle.

Verification
REQ-029 Write 4-word packet (len 4, sop on w0, eop on w3) -> wr_lvl 4, then 4 deq_req -> data in order, out_sop on first, out_eop on last, empty=1.
REQ-030 empty_de_assert=1, write 2 of 3 words -> empty stays 1; third word with eop -> empty 0 next cycle.
REQ-031 len 3 but eop on word 2 -> packet_drop pulse, wr_lvl returns to pre-packet value.
REQ-032 deq_req on empty -> underflow pulse 1 cycle; fill 4096 words then enq_req -> overflow pulse, full=1.
REQ-033 almost_full_value=4: wr_lvl 4091 -> almost_full 0, 4092 -> 1; almost_empty_value=2: wr_lvl 2 -> 1, 3 -> 0.
REQ-034 sw_rstn low mid-packet -> all outputs reset values next cycle; next valid packet stored normally.
